// File: rtl/clk_cfg_sequencer.sv
// Clock configuration change sequencer: gate cog clock, apply cfg,
// wait for oscillator/PLL settle, then ungate.
module clk_cfg_sequencer #(
  parameter int unsigned GATE_CYCLES   = 4,
  parameter int unsigned SWITCH_CYCLES = 8,
  parameter int unsigned SETTLE_CYCLES = 1600000
) (
  input  logic       clock,
  input  logic       res,
  input  logic [6:0] cfg_req,
  output logic [6:0] cfg_act,
  output logic       clk_en,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MAX_GS =
    (GATE_CYCLES > SWITCH_CYCLES) ? GATE_CYCLES : SWITCH_CYCLES;
  localparam int unsigned MAX_C =
    (MAX_GS > SETTLE_CYCLES) ? MAX_GS : SETTLE_CYCLES;
  localparam int unsigned CW = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] GATE_LD   = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] SWITCH_LD = CW'(SWITCH_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [6:0]    cfg_pend_q;
  logic [6:0]    cfg_act_q;
  logic          clk_en_q;
  logic          busy_q;
  logic          done_q;
  logic          new_src_d;
  logic [CW-1:0] wait_ld_d;

  // Only a rising PLLENA/OSCENA needs the long oscillator settle wait.
  always_comb begin
    new_src_d = (cfg_pend_q[6] & ~cfg_act_q[6])
              | (cfg_pend_q[5] & ~cfg_act_q[5]);
    wait_ld_d = new_src_d ? SETTLE_LD : SWITCH_LD;
  end

  always_ff @(posedge clock) begin
    if (res) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cfg_pend_q <= 7'h00;
      cfg_act_q  <= 7'h00;
      clk_en_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cfg_req != cfg_act_q) begin
            cfg_pend_q <= cfg_req;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= GATE_LD;
            state_q    <= GATE;
          end
        end
        GATE: begin
          if (cnt_q == '0) begin
            cfg_act_q <= cfg_pend_q;
            cnt_q     <= wait_ld_d;
            state_q   <= WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            clk_en_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_act = cfg_act_q;
  assign clk_en  = clk_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_clk_cfg_sequencer.sv
// Bench for clk_cfg_sequencer: timeline model compared every cycle,
// directed latency checks, then randomized cfg/reset traffic.
module tb_clk_cfg_sequencer;

  localparam int G  = 4;
  localparam int SW = 2;
  localparam int ST = 16;

  logic       clock = 1'b0;
  logic       res = 1'b1;
  logic [6:0] cfg_req = 7'h00;
  logic [6:0] cfg_act;
  logic       clk_en;
  logic       busy;
  logic       done;

  clk_cfg_sequencer #(
    .GATE_CYCLES  (G),
    .SWITCH_CYCLES(SW),
    .SETTLE_CYCLES(ST)
  ) dut (
    .clock  (clock),
    .res    (res),
    .cfg_req(cfg_req),
    .cfg_act(cfg_act),
    .clk_en (clk_en),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Timeline model: a sequence started at edge s applies cfg at
  // s+G and ungates at s+G+W.
  logic [6:0] m_act;
  logic [6:0] m_pend;
  bit m_en, m_busy, m_done, m_active, m_valid, m_rst;
  int t = 0;
  int m_start, m_w;

  always @(posedge clock) begin
    t++;
    m_done = 1'b0;
    m_rst = 1'b0;
    if (res) begin
      m_act = 7'h00;
      m_en = 1'b1;
      m_busy = 1'b0;
      m_active = 1'b0;
      m_valid = 1'b1;
      m_rst = 1'b1;
    end else if (m_valid) begin
      if (!m_active) begin
        if (cfg_req != m_act) begin
          m_active = 1'b1;
          m_start = t;
          m_pend = cfg_req;
          m_w = ((cfg_req[6] && !m_act[6]) ||
                 (cfg_req[5] && !m_act[5])) ? ST : SW;
          m_en = 1'b0;
          m_busy = 1'b1;
        end
      end else begin
        if (t == m_start + G) m_act = m_pend;
        if (t == m_start + G + m_w) begin
          m_en = 1'b1;
          m_busy = 1'b0;
          m_done = 1'b1;
          m_active = 1'b0;
        end
      end
    end
  end

  logic [6:0] p_act;
  bit p_en, p_valid;
  int low_len = 0;
  int last_low = 0;

  always begin
    @(posedge clock);
    #1;
    if (m_valid) begin
      chk("model", {cfg_act, clk_en, busy, done},
          {m_act, m_en, m_busy, m_done});
      if (p_valid && !m_rst && cfg_act !== p_act)
        chk("act_while_en", {p_en, clk_en}, 0);
      if (clk_en === 1'b0) begin
        low_len++;
      end else begin
        if (low_len != 0) last_low = low_len;
        low_len = 0;
      end
      p_act = cfg_act;
      p_en = clk_en;
      p_valid = 1'b1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    res = 1'b1;
    cfg_req = 7'h00;
    tick(2);
    chk("rst_act", cfg_act, 7'h00);
    chk("rst_en", clk_en, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    res = 1'b0;
    tick(3);
    chk("idle_busy", busy, 0);
    chk("idle_en", clk_en, 1);

    cfg_req = 7'h01;
    tick(1);
    chk("sel_gate_en", clk_en, 0);
    chk("sel_gate_busy", busy, 1);
    tick(3);
    chk("sel_act_old", cfg_act, 7'h00);
    tick(1);
    chk("sel_act_new", cfg_act, 7'h01);
    tick(1);
    chk("sel_still_low", clk_en, 0);
    tick(1);
    chk("sel_ungate", clk_en, 1);
    chk("sel_done", done, 1);
    chk("sel_busy_clr", busy, 0);
    tick(1);
    chk("sel_done_pulse", done, 0);

    cfg_req = 7'h6F;
    tick(5);
    chk("pll_act", cfg_act, 7'h6F);
    tick(15);
    chk("pll_still_low", clk_en, 0);
    tick(1);
    chk("pll_ungate", clk_en, 1);
    chk("pll_done", done, 1);
    tick(1);
    chk("pll_done_pulse", done, 0);
    chk("pll_low_len", last_low, 20);

    cfg_req = 7'h00;
    tick(10);
    chk("to00_act", cfg_act, 7'h00);
    cfg_req = 7'h01;
    tick(3);
    cfg_req = 7'h02;
    tick(2);
    chk("mid_act01", cfg_act, 7'h01);
    tick(2);
    chk("mid_gap_en", clk_en, 1);
    tick(1);
    chk("mid_regate", clk_en, 0);
    tick(3);
    chk("mid_act_hold", cfg_act, 7'h01);
    tick(1);
    chk("mid_act02", cfg_act, 7'h02);
    tick(4);

    cfg_req = 7'h6F;
    tick(25);
    cfg_req = 7'h2F;
    tick(10);
    chk("dis_act", cfg_act, 7'h2F);
    chk("dis_low_len", last_low, 6);

    cfg_req = 7'h00;
    tick(10);
    cfg_req = 7'h6F;
    tick(8);
    chk("rw_in_wait", cfg_act, 7'h6F);
    res = 1'b1;
    tick(1);
    res = 1'b0;
    chk("rw_act", cfg_act, 7'h00);
    chk("rw_en", clk_en, 1);
    chk("rw_busy", busy, 0);
    tick(1);
    chk("rw_restart", clk_en, 0);
    tick(25);

    repeat (3000) begin
      tick(1);
      res = 1'b0;
      if ($urandom_range(0, 99) < 6)
        cfg_req = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 499) == 0)
        res = 1'b1;
    end
    res = 1'b0;
    tick(30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
